// File: rtl/jala_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch queue.
package jala_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
  localparam logic [15:0] DEFAULT_PC_INCR  = 16'd2;

  // Counters must represent 0..DEPTH inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} entries with a registered head word.
module fetch_fifo
  import jala_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = count_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [31:0]   i_data,
  output logic [31:0]   o_head,
  output logic [CW-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_head;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_head  = r_head;
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (i_clear) begin
      // Head keeps its last word so the consumer never sees a spurious value.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_pop && (r_count > CW'(1))) begin
        r_head <= r_mem[r_rd_ptr + AW'(1)];
      end else if (w_push && ((r_count == '0) || (w_pop && (r_count == CW'(1))))) begin
        r_head <= i_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_clear) begin
      assert (!(i_push && w_full && !w_pop));
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// In-order instruction fetch with credit-limited prefetch and redirect flush.
module instr_fetch_queue
  import jala_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [15:0] PC_INCR  = DEFAULT_PC_INCR
) (
  input  logic        CLK,
  input  logic        Rst,
  output logic [15:0] MemAddr,
  output logic        MemRead1,
  input  logic        MemReady,
  input  logic [15:0] MemRdata,
  input  logic        MemValid,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  input  logic        IRWrite,
  output logic [15:0] IROut,
  output logic [15:0] IRPC,
  output logic        IRValid,
  output logic        Busy
);

  localparam int CW = count_width(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_e  r_state;
  fetch_state_e  w_state_next;
  logic [15:0]   r_fetch_pc;
  logic [15:0]   w_fetch_pc_next;
  logic [15:0]   r_resp_pc;
  logic [15:0]   w_resp_pc_next;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] w_outstanding_next;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] w_discard_next;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_inflight;
  logic [31:0]   w_head;
  logic          w_mem_read;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  assign w_inflight = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_mem_read = (r_state == S_RUN) && (w_inflight < DEPTH_W) && !Redirect;
  assign w_accept   = w_mem_read && MemReady;
  assign w_push     = MemValid && (r_state == S_RUN) && !Redirect;
  assign w_pop      = IRWrite && !Redirect;

  assign MemRead1 = w_mem_read;
  assign MemAddr  = r_fetch_pc;
  assign Busy     = (r_state == S_FLUSH);
  assign IRValid  = (w_count != '0);
  assign IROut    = w_head[15:0];
  assign IRPC     = w_head[31:16];

  // Responses come back in order, so the next response PC is a running counter.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (Rst),
    .i_clear (Redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({r_resp_pc, MemRdata}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_comb begin
    w_state_next       = r_state;
    w_fetch_pc_next    = r_fetch_pc;
    w_resp_pc_next     = r_resp_pc;
    w_outstanding_next = r_outstanding;
    w_discard_next     = r_discard;
    if (Redirect) begin
      // Everything still in flight becomes stale, less the response landing now.
      w_discard_next     = r_discard + r_outstanding + CW'(w_accept) - CW'(MemValid);
      w_outstanding_next = '0;
      w_fetch_pc_next    = RedirectPC;
      w_resp_pc_next     = RedirectPC;
      w_state_next       = (w_discard_next != '0) ? S_FLUSH : S_RUN;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_RUN;
        end
        S_RUN: begin
          if (w_accept) begin
            w_fetch_pc_next = r_fetch_pc + PC_INCR;
          end
          if (w_push) begin
            w_resp_pc_next = r_resp_pc + PC_INCR;
          end
          w_outstanding_next = r_outstanding + CW'(w_accept) - CW'(w_push);
        end
        S_FLUSH: begin
          if (MemValid) begin
            w_discard_next = r_discard - CW'(1);
            if (r_discard == CW'(1)) begin
              w_state_next = S_RUN;
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_fetch_pc    <= w_fetch_pc_next;
      r_resp_pc     <= w_resp_pc_next;
      r_outstanding <= w_outstanding_next;
      r_discard     <= w_discard_next;
    end
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction-fetch stage sitting directly upstream of the stage-4 control/decode integration.
- Issues in-order instruction reads on memory port 1 and buffers returned words in a small prefetch queue.
- Presents the head word as IROut, with its PC, to the decode/control stage, which consumes it with IRWrite.
- Handles PC redirects (branch/jump/call/return) by flushing the queue and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, prefetch queue entries (power of 2, 2..16).
- RESET_PC, 16'h0000, fetch address after reset.
- PC_INCR, 2, address increment per instruction word.

Ports:
- CLK  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- MemAddr  out  16  fetch address for port 1.
- MemRead1  out  1  read request; a request is accepted on a cycle where MemRead1 and MemReady are both high.
- MemReady  in  1  memory can accept a request this cycle.
- MemRdata  in  16  returned instruction word.
- MemValid  in  1  MemRdata valid; responses return in request order, latency ≥1 cycle.
- Redirect  in  1  load a new fetch PC (from control PCWrite with PCSource).
- RedirectPC  in  16  new fetch address.
- IRWrite  in  1  consumer pops the head entry; ignored when IRValid=0.
- IROut  out  16  head instruction word.
- IRPC  out  16  address of the head instruction.
- IRValid  out  1  queue non-empty.
- Busy  out  1  high in S_FLUSH.

Behaviour:
- Reset values (async):
  - state=S_IDLE.
  - fetchPC=RESET_PC.
  - count=0, outstanding=0, discard=0.
  - MemRead1=0, MemAddr=RESET_PC.
  - IRValid=0, IROut=0, IRPC=0, Busy=0.
- FSM:
  - S_IDLE: unconditionally moves to S_RUN on the first clock after reset deasserts. No requests are issued in S_IDLE.
  - S_RUN: MemRead1 = (count + outstanding < DEPTH) && !Redirect, combinational from registered state.
    - On acceptance: outstanding++, fetchPC += PC_INCR (mod 2^16, 16'hFFFE+2 wraps to 0), and the entry's PC is recorded.
    - MemAddr = fetchPC.
  - Redirect (any state):
    - Next cycle: count=0, fetchPC=RedirectPC.
    - discard = outstanding plus any request accepted this cycle, minus any MemValid this cycle.
    - outstanding=0.
    - Next state: S_FLUSH if the resulting discard>0, else S_RUN.
  - S_FLUSH: MemRead1=0, Busy=1. Each MemValid decrements discard and is dropped. When discard reaches 0, go to S_RUN. A further Redirect in S_FLUSH only reloads fetchPC; discard is still updated per the rule above.
- Response path:
  - MemValid in S_RUN without Redirect: push {MemRdata, PC}, outstanding--.
  - IRValid rises the cycle after the push (1-cycle response-to-IRValid latency).
- Queue:
  - Push and pop in the same cycle are legal at any occupancy; count is unchanged.
  - The credit rule guarantees no overflow. Push when full is an assertion error.
  - Pop when empty is ignored.
- Head outputs: IROut/IRPC are registered outputs reflecting the head entry. When empty they hold their last value.
- Redirect has priority over IRWrite and MemValid in the same cycle. The queue is cleared and the response counts as discarded.
- Counters: count and outstanding are each $clog2(DEPTH)+1 bits; discard is the same width.
- Rst asserted mid-operation: all state returns to the reset values immediately. Memory responses arriving after reset deassertion without a matching request are an environment error. The bench must reset memory together with this block.

Decomposition:
- Package jala_fetch_pkg:
  - State enum S_IDLE/S_RUN/S_FLUSH.
  - Default RESET_PC and PC_INCR.
  - Count-width function.
- Sub-module fetch_fifo (DEPTH × 32 bits: {pc, instr}):
  - push/pop/clear, head data, count.
  - clear has priority over push.

Test Plan:
- Reset then MemReady=1, memory latency 1, sequential words 16'h1000+i: MemAddr 0,2,4,6 issued on consecutive cycles, stalls at 4 outstanding+queued. IRValid=1 with IROut=16'h1000, IRPC=0 one cycle after the first response.
- Continuous IRWrite=1, latency 1: one instruction delivered per cycle. IRPC sequence 0,2,4,… is gap-free after the initial fill.
- Redirect to 16'h0040 with 3 outstanding, latency 3: Busy=1, no MemRead1 until the 3 stale responses are dropped. First delivered IRPC=16'h0040, with no stale word ever on IROut.
- Redirect coincident with MemValid and IRWrite: queue empties next cycle and the response is dropped (discard = outstanding−1). Then fetch resumes at RedirectPC.
- RESET_PC=16'hFFFC: MemAddr sequence FFFC, FFFE, 0000, 0002.
- Rst pulse asserted mid-fetch (asynchronous, between edges): outputs go to reset values immediately. After release, first MemAddr=RESET_PC and IRValid=0 until a new response arrives.
